// File: rtl/booth_mul_ctrl.sv
// Sequencing controller for a signed radix-2 Booth multiplier (A/Q/Q-1/M registers, counter, FSM).
// Define BOOTH_SKIP_EN to fold the shift into EVAL for no-op iterations (data-dependent latency).
module booth_mul_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    logic                 sub;
    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       b_op;
    logic [WIDTH:0]       sum;
    logic                 carry;
    logic                 last_iter;

    // Ripple-carry adder over the guarded A width; subtract via inverted M and carry-in.
    always_comb begin
        sub   = ({q_q[0], qm1_q} == 2'b10);
        m_ext = {m_q[WIDTH-1], m_q};
        b_op  = sub ? ~m_ext : m_ext;
        carry = sub;
        sum   = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            sum[i] = a_q[i] ^ b_op[i] ^ carry;
            carry  = (a_q[i] & b_op[i]) | (carry & (a_q[i] ^ b_op[i]));
        end
    end

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = mcand;
                    q_d     = mplier;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (q_q[0] != qm1_q) begin
                    a_d     = sum;
                    state_d = SHIFT;
                end else begin
`ifdef BOOTH_SKIP_EN
                    {a_d, q_d, qm1_d} = {a_q[WIDTH], a_q, q_q};
                    if (last_iter) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = EVAL;
                    end
`else
                    state_d = SHIFT;
`endif
                end
            end
            SHIFT: begin
                {a_d, q_d, qm1_d} = {a_q[WIDTH], a_q, q_q};
                if (last_iter) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = EVAL;
                end
            end
            DONE: begin
                // Product and done are registered together so done always flags a valid product.
                product_d = {a_q[WIDTH-1:0], q_q};
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == EVAL) || (state_q == SHIFT);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl: directed and random multiplies against an arithmetic model.
// Latency expectations follow BOOTH_SKIP_EN when it is defined for the build.
module tb_booth_mul_ctrl;

    localparam int W = 8;
`ifdef BOOTH_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int WINDOW = 2 * W + 6;

    logic               clk;
    logic               rst_b;
    logic               start;
    logic [W-1:0]       mcand;
    logic [W-1:0]       mplier;
    logic               busy;
    logic               done;
    logic [2*W-1:0]     product;

    int vectors;
    int miscompares;

    booth_mul_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Iterations whose bit pair {Q[i],Q[i-1]} is 00 or 11 do no arithmetic.
    function automatic int noopCount(input logic [W-1:0] mp);
        int n = 0;
        logic prev = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (mp[i] == prev) n++;
            prev = mp[i];
        end
        return n;
    endfunction

    function automatic int expLatency(input logic [W-1:0] mp);
        return 2 * W + 2 - (SKIP ? noopCount(mp) : 0);
    endfunction

    function automatic logic [2*W-1:0] expProduct(input logic [W-1:0] mc, input logic [W-1:0] mp);
        logic signed [2*W-1:0] p;
        p = $signed(mc) * $signed(mp);
        return p;
    endfunction

    // Runs one multiply; optionally pulses start with other operands at sample intrudeAt.
    task automatic applyStimulus(input string tag, input logic [W-1:0] mc, input logic [W-1:0] mp,
                                 input int intrudeAt);
        int lat = 0;
        int doneCnt = 0;
        int busyCnt = 0;
        logic [2*W-1:0] pAtDone = '0;
        @(negedge clk);
        start  = 1'b1;
        mcand  = mc;
        mplier = mp;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mcand  = W'($urandom);
        mplier = W'($urandom);
        for (int n = 1; n <= WINDOW; n++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                if (lat == 0) begin
                    lat     = n;
                    pAtDone = product;
                end
            end
            if (n == intrudeAt) begin
                start  = 1'b1;
                mcand  = ~mc;
                mplier = mp + 8'd3;
            end else begin
                start  = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput({tag, ".product"}, 32'(pAtDone), 32'(expProduct(mc, mp)));
        checkOutput({tag, ".latency"}, 32'(lat), 32'(expLatency(mp)));
        checkOutput({tag, ".doneCount"}, 32'(doneCnt), 32'd1);
        checkOutput({tag, ".busyCycles"}, 32'(busyCnt), 32'(expLatency(mp) - 2));
        checkOutput({tag, ".productHeld"}, 32'(product), 32'(expProduct(mc, mp)));
    endtask

    initial begin
        int doneSeen;
        vectors     = 0;
        miscompares = 0;
        rst_b  = 1'b0;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.product", 32'(product), 32'd0);
        rst_b = 1'b1;
        @(negedge clk);

        applyStimulus("basic",    8'd3,   8'd5,   0);
        applyStimulus("mixed",    8'hF9,  8'd6,   0);
        applyStimulus("negneg",   8'h80,  8'h80,  0);
        applyStimulus("posneg",   8'h7F,  8'h80,  0);
        applyStimulus("zero",     8'h00,  8'hFF,  0);
        applyStimulus("mpzero",   8'd9,   8'h00,  0);
        applyStimulus("alt55",    8'd9,   8'h55,  0);
        applyStimulus("intrude",  8'd11,  8'hA3,  5);

        // Abandon a multiply with an asynchronous reset in its seventh cycle.
        @(negedge clk);
        start  = 1'b1;
        mcand  = 8'd13;
        mplier = 8'hC5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        checkOutput("midreset.busy", 32'(busy), 32'd0);
        checkOutput("midreset.product", 32'(product), 32'd0);
        doneSeen = 0;
        for (int n = 0; n < WINDOW; n++) begin
            @(negedge clk);
            if (n == 2) rst_b = 1'b1;
            if (done) doneSeen++;
        end
        checkOutput("midreset.noDone", 32'(doneSeen), 32'd0);
        checkOutput("midreset.idleBusy", 32'(busy), 32'd0);
        applyStimulus("afterReset", 8'hF3, 8'd21, 0);

        for (int r = 0; r < 20; r++) begin
            applyStimulus($sformatf("rand%0d", r), W'($urandom), W'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/booth_mul_ctrl.md
Name: booth_mul_ctrl

Overview:
- Sequencing controller for a signed radix-2 Booth multiplier built around the team's ripple-carry parallel adder.
- Holds the A, Q, Q-1 and M registers, an iteration counter and an FSM.
- On each iteration it chooses add, subtract or no-op on the adder datapath, then performs an arithmetic right shift.
- Accepts one multiply at a time via a start/done handshake and holds the product until the next start.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH; WIDTH >= 2.
- CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_b  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- mcand  input  WIDTH  signed multiplicand M; captured when start is accepted
- mplier  input  WIDTH  signed multiplier Q; captured when start is accepted
- busy  output  1  high in EVAL and SHIFT
- done  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  signed result; held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk; reset rst_b is asynchronous, active-low.
- Reset (rst_b=0, any time, including mid-operation):
  - state=IDLE.
  - A, Q, Q-1, M, cnt, product all cleared to 0.
  - busy=0, done=0.
  - Any in-flight multiply is abandoned with no done pulse.
- Registers:
  - A is WIDTH+1 bits (one guard bit), so M = most-negative value does not overflow.
  - Q is WIDTH bits; Q-1 is 1 bit; M is WIDTH bits.
- Adder datapath:
  - Operands: A and M sign-extended to WIDTH+1 bits.
  - sub=1: the M operand is XORed with all-ones and carry-in=1 (two's-complement subtract).
  - sub=0: carry-in=0.
  - Carry-out is discarded; the result is WIDTH+1 bits.
- FSM states: IDLE, EVAL, SHIFT, DONE.
- IDLE:
  - start=1 at a clock edge captures M<=mcand, Q<=mplier, A<=0, Q-1<=0, cnt<=0, then goes to EVAL.
  - start=0 stays in IDLE.
- EVAL, acting on {Q[0],Q-1}:
  - 01: A<=A+M.
  - 10: A<=A-M.
  - 00 or 11: A unchanged.
  - Always goes to SHIFT.
- SHIFT:
  - {A,Q,Q-1} <= arithmetic right shift by 1; A's MSB is replicated.
  - If cnt==WIDTH-1, go to DONE; else cnt<=cnt+1 and go to EVAL.
- DONE:
  - product<={A[WIDTH-1:0],Q}.
  - done=1 for exactly this one cycle.
  - Next state is IDLE unconditionally; start is not sampled in DONE.
- Latency: start accepted at edge k; done is high in the cycle following edge k+2*WIDTH+1, i.e. 2*WIDTH+2 cycles after acceptance. product updates on edge k+2*WIDTH+1 and is stable from then on.
- busy is 1 in EVAL and SHIFT only.
- start while busy or in DONE is ignored; no queueing.
- mcand and mplier may change freely after acceptance.
- Back-to-back: start held high during DONE takes effect in IDLE on the next edge, so the minimum gap between accepted starts is 2*WIDTH+2 cycles.
- Product is exact for all signed operand pairs, including (-2^(WIDTH-1))*(-2^(WIDTH-1)).

Optional Feature:
- Macro: BOOTH_SKIP_EN.
- Defined:
  - In EVAL, when {Q[0],Q-1} is 00 or 11, the shift and counter update are performed in EVAL itself. The FSM then goes straight to EVAL, or to DONE when cnt==WIDTH-1, bypassing SHIFT.
  - Latency = 2*WIDTH+2 minus the number of no-op iterations; minimum WIDTH+2.
  - busy rules are unchanged.
- Not defined: fixed latency exactly as described in Behaviour.

Test Plan:
- Basic: mcand=3, mplier=5, start pulse → product=0x000F; done high exactly 18 cycles after acceptance (WIDTH=8, macro off).
- Mixed sign: mcand=-7 (0xF9), mplier=6 → product=0xFFD6 (-42); busy high for 16 cycles.
- Extremes: (-128)*(-128) → 0x4000; 127*(-128) → 0xC080; 0*(-1) → 0x0000.
- Start while busy: pulse start with new operands 5 cycles after the first start → ignored; first result unchanged; exactly one done pulse.
- Reset mid-operation: drop rst_b at cycle 7 of a multiply → busy=0, product=0, state IDLE, no done pulse. A new start after release gives the correct result.
- BOOTH_SKIP_EN: mplier=0x00, mcand=9 → product=0; done 10 cycles after acceptance. mplier=0x55 → full 18-cycle latency; product matches the macro-off result.
